// File: rtl/seq_mul_unit.sv
// seq_mul_unit: iterative shift-add multiplier (MUL / UMULL / SMULL) with
// valid/ready handshakes on the request and result sides. It produces a
// 2*WIDTH result and NZCV flags.
// Optional feature macro: SEQ_MUL_ACCUM_EN. When defined, op[2] selects a
// multiply-accumulate that adds {acc_hi,acc_lo} in an extra ACC cycle.
module seq_mul_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(N + 1);

`ifdef SEQ_MUL_ACCUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_FIX  = 3'd2,
        S_ACC  = 3'd3,
        S_DONE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_FIX  = 3'd2,
        S_DONE = 3'd4
    } state_t;
`endif

    state_t r_state;
    state_t w_state_next;

    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result_lo;
    logic [WIDTH-1:0] r_result_hi;
    logic [3:0]       r_flags;

    logic [DW-1:0]    r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [DW-1:0]    r_prod;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic             r_long;

    logic             w_accept;
    logic             w_signed_in;
    logic             w_long_in;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_calc_last;
    logic [DW-1:0]    w_step_sum;
    logic [DW-1:0]    w_fixed;
    logic [DW-1:0]    w_final;
    logic             w_final_load;

`ifdef SEQ_MUL_ACCUM_EN
    logic             r_accum;
    logic [DW-1:0]    r_addend;
`else
    logic             w_unused_acc;
    assign w_unused_acc = ^{op[2], acc_hi, acc_lo};
`endif

    // N/Z flags come from the 2W result for long ops and the low word for MUL; C and V are always 0.
    function automatic logic [3:0] calc_flags(input logic is_long, input logic [DW-1:0] v);
        logic n;
        logic z;
        if (is_long) begin
            n = v[DW-1];
            z = (v == DW'(0));
        end else begin
            n = v[WIDTH-1];
            z = (v[WIDTH-1:0] == WIDTH'(0));
        end
        return {n, z, 2'b00};
    endfunction

    assign w_accept    = in_valid && r_in_ready;
    assign w_signed_in = (op[1:0] == 2'b10);
    assign w_long_in   = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
    assign w_calc_last = (r_cnt == CW'(N - 1));

    // Operand magnitudes: SMULL multiplies absolute values; the most negative value maps exactly to 2^(W-1).
    always_comb begin
        w_a_mag = a;
        w_b_mag = b;
        if (w_signed_in && a[WIDTH-1]) begin
            w_a_mag = ~a + WIDTH'(1);
        end else begin
            w_a_mag = a;
        end
        if (w_signed_in && b[WIDTH-1]) begin
            w_b_mag = ~b + WIDTH'(1);
        end else begin
            w_b_mag = b;
        end
    end

    // One CALC step: add the shifted multiplicand for each of the low BITS_PER_CYCLE multiplier bits.
    always_comb begin
        w_step_sum = r_prod;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mplier[j]) begin
                w_step_sum = w_step_sum + (r_mcand << j);
            end else begin
                w_step_sum = w_step_sum;
            end
        end
    end

    // Sign correction applied in FIX, plus selection of the value that lands in the result registers.
    always_comb begin
        w_fixed      = r_neg ? (~r_prod + DW'(1)) : r_prod;
        w_final      = w_fixed;
        w_final_load = 1'b0;
`ifdef SEQ_MUL_ACCUM_EN
        if (r_state == S_ACC) begin
            w_final      = r_prod + r_addend;
            w_final_load = 1'b1;
        end else if (r_state == S_FIX) begin
            w_final      = w_fixed;
            w_final_load = !r_accum;
        end else begin
            w_final      = w_fixed;
            w_final_load = 1'b0;
        end
`else
        if (r_state == S_FIX) begin
            w_final_load = 1'b1;
        end else begin
            w_final_load = 1'b0;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_CALC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (w_calc_last) begin
                    w_state_next = S_FIX;
                end else begin
                    w_state_next = S_CALC;
                end
            end
            S_FIX: begin
`ifdef SEQ_MUL_ACCUM_EN
                if (r_accum) begin
                    w_state_next = S_ACC;
                end else begin
                    w_state_next = S_DONE;
                end
`else
                w_state_next = S_DONE;
`endif
            end
`ifdef SEQ_MUL_ACCUM_EN
            S_ACC: begin
                w_state_next = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Handshake outputs registered from the next state so they track the FSM without combinational paths.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
        end
    end

    // Datapath: capture operands at handshake, then shift-add through CALC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_long   <= 1'b0;
`ifdef SEQ_MUL_ACCUM_EN
            r_accum  <= 1'b0;
            r_addend <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_prod   <= '0;
                        r_cnt    <= '0;
                        r_neg    <= w_signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_long   <= w_long_in;
`ifdef SEQ_MUL_ACCUM_EN
                        r_accum  <= op[2];
                        r_addend <= {acc_hi, acc_lo};
`endif
                    end
                end
                S_CALC: begin
                    r_prod   <= w_step_sum;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt    <= r_cnt + CW'(1);
                end
                S_FIX: begin
                    r_prod <= w_fixed;
                end
                default: begin
                    r_prod <= r_prod;
                end
            endcase
        end
    end

    // Result and flag registers update only on entry to DONE and otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_result_lo <= '0;
            r_result_hi <= '0;
            r_flags     <= 4'b0000;
        end else if (w_final_load) begin
            r_result_lo <= w_final[WIDTH-1:0];
            r_result_hi <= r_long ? w_final[DW-1:WIDTH] : {WIDTH{1'b0}};
            r_flags     <= calc_flags(r_long, w_final);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result_lo = r_result_lo;
    assign result_hi = r_result_hi;
    assign flags     = r_flags;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Bench for seq_mul_unit: two instances (1 and 4 bits per cycle) share the
// same stimulus; a cycle-level reference model derived from the arithmetic
// rules is compared against both on every falling edge, and directed vectors
// pin literal results and latencies.
module tb_seq_mul_unit;

`ifdef SEQ_MUL_ACCUM_EN
    localparam bit ACC_ON = 1'b1;
`else
    localparam bit ACC_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = 32'h0, b = 32'h0, acc_hi = 32'h0, acc_lo = 32'h0;
    logic        ir [2];
    logic        ov [2];
    logic [31:0] rlo [2];
    logic [31:0] rhi [2];
    logic [3:0]  fl [2];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    seq_mul_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .op(op),
        .a(a), .b(b), .acc_hi(acc_hi), .acc_lo(acc_lo), .out_valid(ov[0]),
        .out_ready(out_ready), .result_lo(rlo[0]), .result_hi(rhi[0]), .flags(fl[0]));

    seq_mul_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut1 (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .op(op),
        .a(a), .b(b), .acc_hi(acc_hi), .acc_lo(acc_lo), .out_valid(ov[1]),
        .out_ready(out_ready), .result_lo(rlo[1]), .result_hi(rhi[1]), .flags(fl[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic: returns {flags, hi, lo}.
    function automatic logic [67:0] expect_res(input logic [2:0] o, input logic [31:0] x,
                                                input logic [31:0] y, input logic [31:0] ah,
                                                input logic [31:0] al);
        logic [63:0]        p;
        logic signed [63:0] sx, sy;
        logic               is_long;
        logic [31:0]        hi, lo;
        logic               n, z;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        if (o[1:0] == 2'b10) p = sx * sy;
        else                 p = {32'h0, x} * {32'h0, y};
        if (ACC_ON && o[2]) p = p + {ah, al};
        is_long = (o[1:0] == 2'b01) || (o[1:0] == 2'b10);
        if (is_long) begin
            hi = p[63:32]; lo = p[31:0]; n = hi[31]; z = (p == 64'h0);
        end else begin
            hi = 32'h0; lo = p[31:0]; n = lo[31]; z = (lo == 32'h0);
        end
        return {n, z, 2'b00, hi, lo};
    endfunction

    // Model state per instance: 0 idle, 1 busy, 2 result presented.
    int          m_ph [2];
    int          m_left [2];
    logic [67:0] m_pend [2];
    logic [67:0] m_out [2];
    int          base_lat [2] = '{33, 9};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_ph[i] = 0; m_left[i] = 0; m_pend[i] = 68'h0; m_out[i] = 68'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (m_ph[i])
                    0: if (in_valid) begin
                        m_pend[i] = expect_res(op, a, b, acc_hi, acc_lo);
                        m_left[i] = base_lat[i] + ((ACC_ON && op[2]) ? 1 : 0);
                        m_ph[i] = 1;
                    end
                    1: begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            m_out[i] = m_pend[i];
                            m_ph[i] = 2;
                        end
                    end
                    default: if (out_ready) m_ph[i] = 0;
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("in_ready[%0d]", i), {63'h0, ir[i]}, {63'h0, (m_ph[i] == 0)});
            chk($sformatf("out_valid[%0d]", i), {63'h0, ov[i]}, {63'h0, (m_ph[i] == 2)});
            chk($sformatf("result[%0d]", i), {rhi[i], rlo[i]}, m_out[i][63:0]);
            chk($sformatf("flags[%0d]", i), {60'h0, fl[i]}, {60'h0, m_out[i][67:64]});
        end
    end

    task automatic start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ah, input logic [31:0] al);
        @(negedge clk);
        op = o; a = x; b = y; acc_hi = ah; acc_lo = al; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lat0, input int lat1);
        int l0, l1;
        l0 = -1; l1 = -1;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk);
            #1;
            if (l0 < 0 && ov[0]) l0 = k;
            if (l1 < 0 && ov[1]) l1 = k;
            if (l0 >= 0 && l1 >= 0) break;
        end
        chk({nm, " latency bpc1"}, 64'(l0), 64'(lat0));
        chk({nm, " latency bpc4"}, 64'(l1), 64'(lat1));
    endtask

    task automatic check_res(input string nm, input logic [31:0] hi, input logic [31:0] lo,
                             input logic [3:0] f);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s hi[%0d]", nm, i), {32'h0, rhi[i]}, {32'h0, hi});
            chk($sformatf("%s lo[%0d]", nm, i), {32'h0, rlo[i]}, {32'h0, lo});
            chk($sformatf("%s flags[%0d]", nm, i), {60'h0, fl[i]}, {60'h0, f});
        end
    endtask

    task automatic retire();
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset in_ready", {63'h0, ir[0]}, 64'h1);
        chk("reset out_valid", {63'h0, ov[0]}, 64'h0);
        rst_n = 1'b1;

        start(3'b010, 32'hFFFF_FFFE, 32'h3, 32'h0, 32'h0);
        wait_done("smull neg", 33, 9);
        check_res("smull neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 4'b1000);
        retire();

        start(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0);
        wait_done("umull max", 33, 9);
        check_res("umull max", 32'hFFFF_FFFE, 32'h0000_0001, 4'b1000);
        retire();

        start(3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0);
        wait_done("mul wrap", 33, 9);
        check_res("mul wrap", 32'h0, 32'h0, 4'b0100);
        retire();

        start(3'b010, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0);
        wait_done("smull min", 33, 9);
        check_res("smull min", 32'h4000_0000, 32'h0, 4'b0000);
        retire();

        start(3'b011, 32'd5, 32'd7, 32'h0, 32'h0);
        wait_done("op11 mul", 33, 9);
        check_res("op11 mul", 32'h0, 32'd35, 4'b0000);
        retire();

        start(3'b101, 32'd2, 32'd3, 32'h0, 32'hFFFF_FFFF);
        if (ACC_ON) begin
            wait_done("umlal", 34, 10);
            check_res("umlal", 32'h1, 32'h5, 4'b0000);
        end else begin
            wait_done("umlal", 33, 9);
            check_res("umlal", 32'h0, 32'h6, 4'b0000);
        end
        retire();

        // Backpressure: result held while new requests are presented.
        start(3'b001, 32'h1234, 32'h10, 32'h0, 32'h0);
        wait_done("bp first", 33, 9);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            op = 3'b001; a = 32'd9 + 32'(c); b = 32'd9; in_valid = 1'b1;
            #1;
            chk("bp in_ready", {63'h0, ir[0]}, 64'h0);
            chk("bp out_valid", {63'h0, ov[0]}, 64'h1);
            chk("bp lo stable", {32'h0, rlo[0]}, 64'h12340);
        end
        @(negedge clk); a = 32'd9; out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk("bp idle in_ready", {63'h0, ir[0]}, 64'h1);
        chk("bp idle out_valid", {63'h0, ov[0]}, 64'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_done("bp second", 33, 9);
        check_res("bp second", 32'h0, 32'd81, 4'b0000);
        retire();

        // Reset in the middle of CALC.
        start(3'b001, 32'h1234, 32'h5678, 32'h0, 32'h0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_res("mid reset", 32'h0, 32'h0, 4'b0000);
        chk("mid reset out_valid", {63'h0, ov[0]}, 64'h0);
        chk("mid reset in_ready", {63'h0, ir[0]}, 64'h1);
        @(negedge clk); rst_n = 1'b1;
        start(3'b001, 32'd7, 32'd6, 32'h0, 32'h0);
        wait_done("post reset", 33, 9);
        check_res("post reset", 32'h0, 32'd42, 4'b0000);
        retire();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
